burst_gate_sequencer: RTL and testbench
=======================================

Name: burst_gate_sequencer

Overview:
- Sequences the chroma PLL loop filter once per video line.
- Detects the hsync leading edge and generates the burst_active gate at a programmed offset and length.
- Suppresses bursts on vblank lines and drops to a no-sync state when hsync disappears.
- Qualifies PLL lock by watching the loop filter's offset output settle line-to-line; drives burst_active into the loop filter and consumes its offset_out.

Parameters:
- CNT_W, 12: width of the line position counter.
- BURST_START, 40: cycles from hsync edge (cycle 0) to first burst_active cycle. Range 2..2^CNT_W-1.
- BURST_LEN, 64: burst_active high duration in cycles. Range 1..127, matching the loop filter's 7-bit sample counter.
- HSYNC_TIMEOUT, 2000: cycles without an hsync edge before entering NO_SYNC. Must exceed BURST_START+BURST_LEN and be < 2^CNT_W.
- LOCK_TOL, 16: maximum |offset delta| between consecutive qualifying lines counted as "settled".
- LOCK_LINES, 32: consecutive settled lines required to assert locked. Range 1..255.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- hsync  in  1  horizontal sync, active high, already synchronous to clk
- vblank  in  1  vertical blanking flag, synchronous; sampled at the hsync edge
- offset_in  in  16 signed  loop filter offset_out
- burst_active  out  1  burst gate to the loop filter (registered)
- line_start  out  1  one-cycle pulse on the cycle after an hsync edge (registered)
- sync_ok  out  1  high when not in NO_SYNC (registered)
- locked  out  1  PLL lock qualifier (registered)

Behaviour:
- Reset: every output is 0, state = NO_SYNC, line counter = 0, settled counter = 0, prev_valid = 0, hsync_d = 0.
- Edge definition: an edge occurs on the cycle where hsync = 1 and hsync_d = 0; that cycle is cycle 0. hsync_d is a register of hsync.
- States: NO_SYNC, WAIT_BURST, BURST, WAIT_HSYNC. sync_ok = (state != NO_SYNC); burst_active = (state == BURST), both registered.
- An edge in any state:
  - clears the line counter and pulses line_start at cycle 1;
  - moves to WAIT_BURST if vblank = 0 at cycle 0, otherwise to WAIT_HSYNC.
- WAIT_BURST -> BURST:
  - burst_active is high for exactly cycles BURST_START .. BURST_START+BURST_LEN-1;
  - the state then moves to WAIT_HSYNC.
- Edge during BURST: the burst truncates and burst_active is 0 from cycle 1. The loop filter then sees a short burst; this is accepted behaviour.
- Line counter:
  - increments every cycle outside NO_SYNC and saturates at all-ones;
  - if it reaches HSYNC_TIMEOUT with no edge, the state moves to NO_SYNC;
  - sync_ok and locked are 0 from the next cycle, and settled counter and prev_valid are cleared.
- Lock check, performed at each edge cycle while prev_valid = 1 and vblank = 0:
  - delta = offset_in - offset_prev, computed in 17-bit signed (no overflow).
  - If |delta| <= LOCK_TOL, the settled counter increments, saturating at LOCK_LINES.
  - Otherwise the settled counter is cleared and locked is cleared.
  - locked is set on the cycle after the settled counter reaches LOCK_LINES, and stays set until a failed check or NO_SYNC.
- offset_prev is captured at every non-vblank edge and sets prev_valid = 1.
- A vblank edge neither checks nor updates offset_prev, and the settled counter is held.
- The first edge after NO_SYNC or reset only captures offset_prev; no check is performed.
- An asynchronous reset mid-burst forces burst_active low immediately.

Test Plan:
- Reset, then an hsync edge every 1716 cycles with vblank = 0 and defaults -> burst_active rises exactly 40 cycles after each edge and stays high for 64 cycles; line_start pulses at cycle 1 of each line; sync_ok = 1 from the first edge.
- Same timing, but a second edge injected 70 cycles after the first -> burst_active 1 for cycles 40..70, then 0 from cycle 71; a full 64-cycle burst occurs 40 cycles after the second edge.
- Edge with vblank = 1 -> no burst_active on that line; line_start still pulses; the settled counter is unchanged.
- Stop hsync after one edge -> sync_ok and burst_active fall at cycle 2001; locked = 0. The next edge restores sync_ok, and locked remains 0 for at least LOCK_LINES+1 further lines.
- offset_in steps by 10 per line for 33 lines -> locked = 1 the cycle after the 33rd edge (32 checks). A single step of 17 then clears locked the cycle after that edge. Also run offset_in = -32768 then +32767 -> fail with no overflow.
- Deassert rst_n inside a burst -> burst_active = 0 asynchronously and all outputs are 0. After release, no burst occurs until the next hsync edge.

Source files
------------

// File: rtl/burst_gate_sequencer_if.sv
// Handshake bundle between the line sequencer and its video/loop-filter
// neighbours: sync/blanking and filter offset in, burst gate and status out.
interface burst_gate_sequencer_if;
   logic               hsync;
   logic               vblank;
   logic signed [15:0] offset_in;
   logic               burst_active;
   logic               line_start;
   logic               sync_ok;
   logic               locked;

   // Driver side: produces sync/blanking/offset and observes the gate/status
   modport master (
      output hsync, vblank, offset_in,
      input  burst_active, line_start, sync_ok, locked
   );

   // Sequencer side
   modport slave (
      input  hsync, vblank, offset_in,
      output burst_active, line_start, sync_ok, locked
   );
endinterface

// File: rtl/burst_gate_sequencer.sv
// Per-line burst gate sequencer for the chroma PLL loop filter.
// Finds the hsync leading edge, opens burst_active at a fixed offset for a
// fixed length, skips vblank lines, falls back to NO_SYNC when hsync goes
// missing, and qualifies lock from line-to-line settling of the filter offset.
module burst_gate_sequencer #(
   parameter int CNT_W         = 12,
   parameter int BURST_START   = 40,
   parameter int BURST_LEN     = 64,
   parameter int HSYNC_TIMEOUT = 2000,
   parameter int LOCK_TOL      = 16,
   parameter int LOCK_LINES    = 32
) (
   input logic                   clk,
   input logic                   rst_n,
   burst_gate_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      NO_SYNC    = 2'd0,
      WAIT_BURST = 2'd1,
      BURST      = 2'd2,
      WAIT_HSYNC = 2'd3
   } state_t;

   // Counter holds the position within the line: cycle k after the edge reads k.
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] BURST_FIRST = CNT_W'(BURST_START);
   localparam logic [CNT_W-1:0] BURST_END   = CNT_W'(BURST_START + BURST_LEN);
   localparam logic [CNT_W-1:0] TIMEOUT     = CNT_W'(HSYNC_TIMEOUT);
   localparam logic [7:0]       SET_MAX     = 8'(LOCK_LINES);
   localparam logic [16:0]      TOL         = 17'(LOCK_TOL);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [7:0]         settled_q, settled_d;
   logic               prev_valid_q, prev_valid_d;
   logic               locked_q, locked_d;
   logic signed [15:0] offset_prev_q, offset_prev_d;
   logic               hsync_q;
   logic               burst_active_q, line_start_q, sync_ok_q;

   logic               hs_edge;
   logic signed [16:0] delta;
   logic               settle_ok;

   // Magnitude of a 17-bit two's-complement difference; the input range
   // (+/-65535) always fits the unsigned 17-bit result.
   function automatic logic [16:0] abs_delta(input logic [16:0] d);
      abs_delta = d[16] ? (17'd0 - d) : d;
   endfunction

   // Next-state: edge handling, burst window, hsync timeout and lock qualification
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      settled_d     = settled_q;
      prev_valid_d  = prev_valid_q;
      offset_prev_d = offset_prev_q;
      locked_d      = locked_q;

      hs_edge   = bus.hsync & ~hsync_q;
      // Sign-extend both operands so extreme offsets cannot wrap
      delta     = {bus.offset_in[15], bus.offset_in} - {offset_prev_q[15], offset_prev_q};
      settle_ok = (abs_delta(delta) <= TOL);

      if (hs_edge) begin
         cnt_d   = CNT_ONE;
         state_d = bus.vblank ? WAIT_HSYNC : WAIT_BURST;
         // Blanking lines leave the offset history and settled count alone
         if (!bus.vblank) begin
            offset_prev_d = bus.offset_in;
            prev_valid_d  = 1'b1;
            if (prev_valid_q) begin
               if (settle_ok) begin
                  settled_d = (settled_q >= SET_MAX) ? SET_MAX : settled_q + 8'd1;
                  if (settled_d == SET_MAX) locked_d = 1'b1;
               end else begin
                  settled_d = 8'd0;
                  locked_d  = 1'b0;
               end
            end
         end
      end else if (state_q != NO_SYNC) begin
         if (cnt_q >= TIMEOUT) begin
            state_d      = NO_SYNC;
            settled_d    = 8'd0;
            prev_valid_d = 1'b0;
            locked_d     = 1'b0;
         end else begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
            case (state_q)
               WAIT_BURST: if (cnt_d == BURST_FIRST) state_d = BURST;
               BURST:      if (cnt_d == BURST_END)   state_d = WAIT_HSYNC;
               default:    ;
            endcase
         end
      end
   end

   // State, counters and registered outputs; outputs follow the next state so
   // burst_active is high exactly while the line position is inside the window
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= NO_SYNC;
         cnt_q          <= '0;
         settled_q      <= 8'd0;
         prev_valid_q   <= 1'b0;
         locked_q       <= 1'b0;
         hsync_q        <= 1'b0;
         burst_active_q <= 1'b0;
         line_start_q   <= 1'b0;
         sync_ok_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         settled_q      <= settled_d;
         prev_valid_q   <= prev_valid_d;
         locked_q       <= locked_d;
         hsync_q        <= bus.hsync;
         burst_active_q <= (state_d == BURST);
         line_start_q   <= hs_edge;
         sync_ok_q      <= (state_d != NO_SYNC);
      end
   end

   // Previous-line offset is pure data, qualified by prev_valid_q
   always_ff @(posedge clk) begin
      offset_prev_q <= offset_prev_d;
   end

   assign bus.burst_active = burst_active_q;
   assign bus.line_start   = line_start_q;
   assign bus.sync_ok      = sync_ok_q;
   assign bus.locked       = locked_q;

endmodule

// File: tb/tb_burst_gate_sequencer.sv
// Directed bench for burst_gate_sequencer: line timing, truncated bursts,
// vblank lines, hsync loss, lock qualification and asynchronous reset.
module tb_burst_gate_sequencer;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   // Per-line observations filled in by run_line
   int   first_hi, last_hi, hi_cnt, ls_cnt;
   logic ba0, lk0, ls1, so1, lk1;

   burst_gate_sequencer_if bus_if ();

   burst_gate_sequencer #(
      .CNT_W(12), .BURST_START(40), .BURST_LEN(64),
      .HSYNC_TIMEOUT(2000), .LOCK_TOL(16), .LOCK_LINES(32)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus_if)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one hsync edge at the current cycle (cycle 0), then observe cycles
   // 1..period-1; returns positioned at the cycle 0 of the next line.
   task automatic run_line(input logic vb, input logic signed [15:0] off, input int period);
      ba0 = bus_if.burst_active;
      lk0 = bus_if.locked;
      bus_if.hsync     = 1'b1;
      bus_if.vblank    = vb;
      bus_if.offset_in = off;
      tick();
      bus_if.hsync = 1'b0;
      ls1 = bus_if.line_start;
      so1 = bus_if.sync_ok;
      lk1 = bus_if.locked;
      first_hi = -1; last_hi = -1; hi_cnt = 0; ls_cnt = 0;
      for (int k = 1; k < period; k++) begin
         if (bus_if.burst_active) begin
            if (first_hi < 0) first_hi = k;
            last_hi = k;
            hi_cnt++;
         end
         if (bus_if.line_start) ls_cnt++;
         tick();
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus_if.hsync = 1'b0; bus_if.vblank = 1'b0; bus_if.offset_in = '0;
      repeat (3) tick();
      total++; if (bus_if.burst_active !== 1'b0) begin bad++; $display("FAIL rst_burst_active: got %b expected 0", bus_if.burst_active); end
      total++; if (bus_if.line_start !== 1'b0) begin bad++; $display("FAIL rst_line_start: got %b expected 0", bus_if.line_start); end
      total++; if (bus_if.sync_ok !== 1'b0) begin bad++; $display("FAIL rst_sync_ok: got %b expected 0", bus_if.sync_ok); end
      total++; if (bus_if.locked !== 1'b0) begin bad++; $display("FAIL rst_locked: got %b expected 0", bus_if.locked); end
      rst_n = 1'b1;
      repeat (3) tick();
      total++; if (bus_if.sync_ok !== 1'b0) begin bad++; $display("FAIL nosync_before_edge: got %b expected 0", bus_if.sync_ok); end
   endtask

   task automatic test_line_timing();
      for (int i = 0; i < 3; i++) begin
         run_line(1'b0, 16'sd0, 1716);
         total++; if (first_hi !== 40) begin bad++; $display("FAIL line%0d_burst_first: got %0d expected 40", i, first_hi); end
         total++; if (last_hi !== 103) begin bad++; $display("FAIL line%0d_burst_last: got %0d expected 103", i, last_hi); end
         total++; if (hi_cnt !== 64) begin bad++; $display("FAIL line%0d_burst_len: got %0d expected 64", i, hi_cnt); end
         total++; if (ls1 !== 1'b1 || ls_cnt !== 1) begin bad++; $display("FAIL line%0d_line_start: got c1=%b count=%0d expected c1=1 count=1", i, ls1, ls_cnt); end
         total++; if (so1 !== 1'b1) begin bad++; $display("FAIL line%0d_sync_ok: got %b expected 1", i, so1); end
      end
   endtask

   task automatic test_back_to_back();
      run_line(1'b0, 16'sd0, 70);
      total++; if (first_hi !== 40 || last_hi !== 69) begin bad++; $display("FAIL trunc_window: got %0d..%0d expected 40..69", first_hi, last_hi); end
      run_line(1'b0, 16'sd0, 1716);
      total++; if (ba0 !== 1'b1) begin bad++; $display("FAIL trunc_cycle70: got %b expected 1", ba0); end
      total++; if (first_hi !== 40 || last_hi !== 103 || hi_cnt !== 64) begin bad++; $display("FAIL after_trunc_window: got %0d..%0d n=%0d expected 40..103 n=64", first_hi, last_hi, hi_cnt); end
   endtask

   task automatic test_timeout();
      logic s2000, s2001, b2001, l2001;
      s2000 = 1'b0; s2001 = 1'b1; b2001 = 1'b1; l2001 = 1'b1;
      bus_if.hsync = 1'b1; bus_if.vblank = 1'b0; bus_if.offset_in = 16'sd0;
      tick();
      bus_if.hsync = 1'b0;
      for (int k = 1; k <= 2100; k++) begin
         if (k == 2000) s2000 = bus_if.sync_ok;
         if (k == 2001) begin
            s2001 = bus_if.sync_ok; b2001 = bus_if.burst_active; l2001 = bus_if.locked;
         end
         tick();
      end
      total++; if (s2000 !== 1'b1) begin bad++; $display("FAIL timeout_sync_c2000: got %b expected 1", s2000); end
      total++; if (s2001 !== 1'b0) begin bad++; $display("FAIL timeout_sync_c2001: got %b expected 0", s2001); end
      total++; if (b2001 !== 1'b0 || l2001 !== 1'b0) begin bad++; $display("FAIL timeout_burst_locked: got %b/%b expected 0/0", b2001, l2001); end
   endtask

   task automatic test_lock_acquire();
      int early;
      early = 0;
      for (int i = 1; i <= 33; i++) begin
         run_line(1'b0, 16'(10 * i), 150);
         if (i == 1) begin
            total++; if (so1 !== 1'b1) begin bad++; $display("FAIL sync_restored: got %b expected 1", so1); end
         end
         if (i < 33 && lk1 !== 1'b0) early++;
         if (i == 32) begin
            total++; if (lk1 !== 1'b0) begin bad++; $display("FAIL lock_after_31_checks: got %b expected 0", lk1); end
         end
      end
      total++; if (early !== 0) begin bad++; $display("FAIL lock_early: got %0d lines locked expected 0", early); end
      total++; if (lk1 !== 1'b1) begin bad++; $display("FAIL lock_after_32_checks: got %b expected 1", lk1); end
      run_line(1'b0, 16'sd346, 150);
      total++; if (lk1 !== 1'b1) begin bad++; $display("FAIL tol_plus16: got %b expected 1", lk1); end
      run_line(1'b0, 16'sd330, 150);
      total++; if (lk1 !== 1'b1) begin bad++; $display("FAIL tol_minus16: got %b expected 1", lk1); end
      run_line(1'b0, 16'sd347, 150);
      total++; if (lk0 !== 1'b1 || lk1 !== 1'b0) begin bad++; $display("FAIL tol_plus17: got c0=%b c1=%b expected c0=1 c1=0", lk0, lk1); end
   endtask

   task automatic test_vblank();
      for (int j = 1; j <= 31; j++) run_line(1'b0, 16'(347 + 10 * j), 150);
      total++; if (lk1 !== 1'b0) begin bad++; $display("FAIL vb_pre_31: got %b expected 0", lk1); end
      run_line(1'b1, 16'sd12345, 150);
      total++; if (first_hi !== -1) begin bad++; $display("FAIL vb_no_burst: got first=%0d expected -1", first_hi); end
      total++; if (ls1 !== 1'b1 || ls_cnt !== 1) begin bad++; $display("FAIL vb_line_start: got c1=%b count=%0d expected c1=1 count=1", ls1, ls_cnt); end
      total++; if (lk1 !== 1'b0) begin bad++; $display("FAIL vb_no_check: got %b expected 0", lk1); end
      run_line(1'b0, 16'sd667, 150);
      total++; if (lk1 !== 1'b1) begin bad++; $display("FAIL vb_settled_held: got %b expected 1", lk1); end
   endtask

   task automatic test_overflow();
      run_line(1'b0, -16'sd32448, 150);
      total++; if (lk1 !== 1'b0) begin bad++; $display("FAIL jump_clears_lock: got %b expected 0", lk1); end
      for (int j = 1; j <= 32; j++) run_line(1'b0, 16'(-32448 - 10 * j), 150);
      total++; if (lk1 !== 1'b1) begin bad++; $display("FAIL relock_at_min: got %b expected 1", lk1); end
      run_line(1'b0, 16'sd32767, 150);
      total++; if (lk1 !== 1'b0) begin bad++; $display("FAIL min_to_max_delta: got %b expected 0", lk1); end
   endtask

   task automatic test_reset_mid_burst();
      int stray_ba, stray_so;
      stray_ba = 0; stray_so = 0;
      bus_if.hsync = 1'b1; bus_if.vblank = 1'b0; bus_if.offset_in = 16'sd0;
      tick();
      bus_if.hsync = 1'b0;
      repeat (49) tick();
      total++; if (bus_if.burst_active !== 1'b1) begin bad++; $display("FAIL pre_reset_burst: got %b expected 1", bus_if.burst_active); end
      #2 rst_n = 1'b0;
      #1;
      total++; if ({bus_if.burst_active, bus_if.line_start, bus_if.sync_ok, bus_if.locked} !== 4'b0000)
         begin bad++; $display("FAIL async_reset_outputs: got %b expected 0000", {bus_if.burst_active, bus_if.line_start, bus_if.sync_ok, bus_if.locked}); end
      tick(); tick();
      rst_n = 1'b1;
      for (int k = 0; k < 300; k++) begin
         if (bus_if.burst_active) stray_ba++;
         if (bus_if.sync_ok) stray_so++;
         tick();
      end
      total++; if (stray_ba !== 0 || stray_so !== 0) begin bad++; $display("FAIL post_reset_idle: got ba=%0d so=%0d cycles expected 0/0", stray_ba, stray_so); end
      run_line(1'b0, 16'sd0, 200);
      total++; if (first_hi !== 40 || last_hi !== 103 || so1 !== 1'b1) begin bad++; $display("FAIL post_reset_line: got %0d..%0d so=%b expected 40..103 so=1", first_hi, last_hi, so1); end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_line_timing();
      test_back_to_back();
      test_timeout();
      test_lock_acquire();
      test_vblank();
      test_overflow();
      test_reset_mid_burst();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
